// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues word fetches to a synchronous ROM and queues {instr, pc}.
// Latency: two cycles from reset release or redirect to the first instr_valid (issue, then push).
// Backpressure: instr_ready low fills the queue; fetch stalls once queued + in-flight reaches DEPTH.
// Optional build macro FETCH_PREFETCH_STATS_EN adds saturating stat_fetched / stat_flushed counters.
module fetch_prefetch_queue #(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00010000
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] mem_addr,
  input  logic [ILEN-1:0] mem_r_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_bits,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PREFETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] fetch_pc;

  logic [ILEN-1:0] q_bits [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  logic            pop;
  logic            push;
  logic            issue;
  // Entries that are queued or will land in the queue, after this cycle's pop.
  logic [CW:0]     occupancy;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign instr_valid = (count != '0);
  assign instr_bits  = q_bits[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign mem_addr    = fetch_pc;

  // Handshake decode: a new fetch is only issued if its return is guaranteed a free slot.
  always_comb begin
    pop       = instr_valid & instr_ready;
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue     = ~redirect_valid & (occupancy < DEPTH_W);
    push      = inflight & ~redirect_valid;
  end

  // Fetch sequencing and queue bookkeeping; redirect flushes everything and restarts fetch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= RESET_VECTOR;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // Masking rather than slicing keeps the low address bits formally consumed.
      fetch_pc <= redirect_addr & ~XLEN'(3);
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: ROM data returns one cycle after issue and is paired with its PC.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      q_bits[wr_ptr] <= mem_r_data;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef FETCH_PREFETCH_STATS_EN
  logic [32:0] fetched_sum;
  logic [32:0] flushed_sum;

  // Saturating adders; a flush discards what is queued or in flight, minus a same-cycle pop.
  always_comb begin
    fetched_sum = {1'b0, stat_fetched} + 33'(push);
    flushed_sum = {1'b0, stat_flushed} + 33'(occupancy);
  end

  // Statistics counters, cleared by reset and clamped at all-ones.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      if (redirect_valid)
        stat_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a queue-level reference model.
// The model tracks the instruction stream as an ordered list of {pc, bits}.
// Every negedge the DUT outputs are compared against it; literal checks pin key points.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_r_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_bits;
  logic [31:0] instr_pc;
`ifdef FETCH_PREFETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  fetch_prefetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_VECTOR(32'h00010000)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_r_data     (mem_r_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_bits     (instr_bits),
    .instr_pc       (instr_pc)
`ifdef FETCH_PREFETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  // ROM contents: word k above 0x10000 holds value k.
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a - 32'h0001_0000) >> 2;
  endfunction

  // Synchronous ROM: data for the address presented in the previous cycle.
  always @(posedge clock) mem_r_data <= rom_f(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream as an ordered list, plus one outstanding fetch.
  logic [31:0] m_pc[$];
  logic [31:0] m_bits[$];
  bit          m_inf = 0;
  logic [31:0] m_inf_pc = '0;
  logic [31:0] m_fpc = '0;
  bit          m_ok = 0;
  int          m_fetched = 0;
  int          m_flushed = 0;

  always @(posedge clock) begin : model
    int sz;
    bit p;
    sz = m_pc.size();
    p  = m_ok && (sz != 0) && (instr_ready === 1'b1);
    if (reset === 1'b0) begin
      m_pc.delete();
      m_bits.delete();
      m_inf     = 0;
      m_fpc     = 32'h0001_0000;
      m_fetched = 0;
      m_flushed = 0;
      m_ok      = 1;
    end else if (m_ok) begin
      if (redirect_valid) begin
        m_flushed = m_flushed + sz - int'(p) + int'(m_inf);
        m_pc.delete();
        m_bits.delete();
        m_inf = 0;
        m_fpc = redirect_addr & ~32'h3;
      end else begin
        if (p) begin
          void'(m_pc.pop_front());
          void'(m_bits.pop_front());
        end
        if (m_inf) begin
          m_pc.push_back(m_inf_pc);
          m_bits.push_back(rom_f(m_inf_pc));
          m_fetched++;
        end
        if (sz + int'(m_inf) - int'(p) < DEPTH) begin
          m_inf    = 1;
          m_inf_pc = m_fpc;
          m_fpc    = m_fpc + 32'd4;
        end else begin
          m_inf = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_ok) begin
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_pc.size() != 0});
      chk("mem_addr", mem_addr, m_fpc);
      if (m_pc.size() != 0) begin
        chk("instr_pc", instr_pc, m_pc[0]);
        chk("instr_bits", instr_bits, m_bits[0]);
      end
`ifdef FETCH_PREFETCH_STATS_EN
      chk("stat_fetched", stat_fetched, m_fetched);
      chk("stat_flushed", stat_flushed, m_flushed);
`endif
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    reset          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    tick(2);

    // 1: streaming from reset with ready held high
    instr_ready = 1'b1;
    chk("t1_reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("t1_reset_addr", mem_addr, 32'h0001_0000);
    reset = 1'b1;
    tick();
    chk("t1_c1_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t1_c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_c2_pc", instr_pc, 32'h0001_0000);
    chk("t1_c2_bits", instr_bits, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t1_stream_pc", instr_pc, 32'h0001_0000 + 32'(4 * k));
      chk("t1_stream_bits", instr_bits, 32'(k));
    end

    // 2: consumer stalled fills the queue, then drains into a continuous stream
    instr_ready = 1'b0;
    hold_reset();
    reset = 1'b1;
    tick(5);
    chk("t2_full_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_full_head", instr_pc, 32'h0001_0000);
    chk("t2_full_addr", mem_addr, 32'h0001_0010);
    tick();
    chk("t2_stuck_head", instr_pc, 32'h0001_0000);
    chk("t2_stuck_addr", mem_addr, 32'h0001_0010);
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_drain_pc", instr_pc, 32'h0001_0004 + 32'(4 * k));
    end

    // 3: redirect with three entries queued and one fetch in flight
    instr_ready = 1'b0;
    hold_reset();
    reset = 1'b1;
    tick(4);
    chk("t3_pre_head", instr_pc, 32'h0001_0000);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0001_0043;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_flush_addr", mem_addr, 32'h0001_0040);
`ifdef FETCH_PREFETCH_STATS_EN
    chk("t3_flushed", stat_flushed, 32'd4);
`endif
    tick();
    chk("t3_c1_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t3_head_pc", instr_pc, 32'h0001_0040);
    chk("t3_head_bits", instr_bits, 32'h0000_0010);

    // 4: redirect coincident with a pop
    instr_ready = 1'b1;
    tick(3);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0002_0000;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", {31'b0, instr_valid}, 32'd0);
    tick(2);
    chk("t4_head_pc", instr_pc, 32'h0002_0000);

    // 5: fetch PC wraps through the top of the address space
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick(2);
    chk("t5_top_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_pc", instr_pc, 32'h0000_0000);
    tick();
    chk("t5_next_pc", instr_pc, 32'h0000_0004);

    // 6: reset asserted mid-stream with a full queue
    instr_ready = 1'b0;
    tick(6);
    chk("t6_full_valid", {31'b0, instr_valid}, 32'd1);
    reset = 1'b0;
    tick();
    chk("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'h0001_0000);
    reset = 1'b1;
    instr_ready = 1'b1;
    tick(2);
    chk("t6_restart_pc", instr_pc, 32'h0001_0000);
    chk("t6_restart_bits", instr_bits, 32'd0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
